cp0_unit: RTL and testbench

Parametrised coprocessor-0 for the pipelined MIPS core, the successor to the single-cycle CP0. It adds a configurable number of hardware interrupt lines, an optional Count/Compare timer, delay-slot (BD) tracking and interrupt-over-exception arbitration. It sits beside the M stage: the pipeline presents the merged exception code and PC there, and the unit raises `req` to flush the pipeline and redirect fetch to the handler.

---
 rtl/cp0_unit_pkg.sv | 27 ++
 rtl/cp0_unit_timer.sv | 30 +++
 rtl/cp0_unit.sv | 119 +++++++++++
 tb/tb_cp0_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register addresses, field bit positions and exception codes.
package cp0_defs;

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  localparam int unsigned BIT_IE    = 0;
  localparam int unsigned BIT_EXL   = 1;
  localparam int unsigned BIT_IM_LO = 10;
  localparam int unsigned BIT_IP_LO = 10;
  localparam int unsigned BIT_TI    = 30;
  localparam int unsigned BIT_BD    = 31;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

endpackage

// File: rtl/cp0_unit_timer.sv
// Count/Compare timer: free-running Count, Compare match raises TI until Compare is rewritten.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  // Count increments or loads; Compare write clears TI and beats a same-edge match.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      count <= wr_count ? wdata : count + 32'd1;
      if (wr_compare) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if ((count == compare) && (compare != '0)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// Pipelined CP0: SR/Cause/EPC/PRId, hardware interrupts, optional timer, BD tracking.
module cp0_unit
  import cp0_defs::*;
#(
  parameter int unsigned HWINT_N  = 6,
  parameter bit          TIMER_EN = 1'b1,
  parameter logic [31:0] PRID     = 32'h0000_4010
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        cp0_in,
  output logic [31:0]        cp0_out,
  input  logic [31:0]        vpc,
  input  logic               bd_in,
  input  logic [4:0]         exc_code,
  input  logic               exl_clr,
  input  logic [HWINT_N-1:0] hwint,
  output logic               req,
  output logic [31:0]        epc_out
);

  logic [5:0]         sr_im;
  logic               sr_exl;
  logic               sr_ie;
  logic               cause_bd;
  logic [4:0]         cause_exc;
  logic [HWINT_N-1:0] ip_hw;
  logic [31:0]        epc;
  logic [5:0]         ip;
  logic [31:0]        count;
  logic [31:0]        compare;
  logic               ti;
  logic               int_req;
  logic               exc_req;
  logic               wr_en;
  logic [31:0]        epc_vpc;

  // An mtc0 in the same cycle as req is discarded, including timer writes.
  assign wr_en = en & ~req;

  generate
    if (TIMER_EN) begin : g_timer
      cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_count   (wr_en && (cp0_addr == ADDR_COUNT)),
        .wr_compare (wr_en && (cp0_addr == ADDR_COMPARE)),
        .wdata      (cp0_in),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
      );
    end else begin : g_no_timer
      assign count   = '0;
      assign compare = '0;
      assign ti      = 1'b0;
    end
  endgenerate

  // Map the sampled lines onto IP[15:10]; the timer shares the top line.
  always_comb begin
    ip = '0;
    for (int unsigned i = 0; i < HWINT_N; i++) ip[i] = ip_hw[i];
    ip[5] = ip[5] | ti;
  end

  assign int_req = (|(ip & sr_im)) & sr_ie & ~sr_exl & ~reset;
  assign exc_req = (exc_code != 5'd0) & ~sr_exl & ~reset;
  assign req     = int_req | exc_req;

  assign epc_vpc = bd_in ? (vpc - 32'd4) : vpc;
  assign epc_out = (en && (cp0_addr == ADDR_EPC)) ? {cp0_in[31:2], 2'b00} : epc;

  // Combinational register read.
  always_comb begin
    cp0_out = '0;
    case (cp0_addr)
      ADDR_COUNT:   cp0_out = count;
      ADDR_COMPARE: cp0_out = compare;
      ADDR_SR:      cp0_out = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
      ADDR_CAUSE:   cp0_out = {cause_bd, ti, 14'b0, ip, 3'b0, cause_exc, 2'b00};
      ADDR_EPC:     cp0_out = epc;
      ADDR_PRID:    cp0_out = PRID;
      default:      cp0_out = '0;
    endcase
  end

  // Exception entry beats mtc0 and eret; eret clears EXL after any SR write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_exc <= '0;
      ip_hw     <= '0;
      epc       <= '0;
    end else begin
      ip_hw <= hwint;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_exc <= int_req ? 5'(EXC_INT) : exc_code;
        cause_bd  <= bd_in;
        epc       <= {epc_vpc[31:2], 2'b00};
      end else begin
        if (en && (cp0_addr == ADDR_SR)) begin
          sr_im  <= cp0_in[BIT_IM_LO +: 6];
          sr_exl <= cp0_in[BIT_EXL];
          sr_ie  <= cp0_in[BIT_IE];
        end
        if (en && (cp0_addr == ADDR_EPC)) epc <= {cp0_in[31:2], 2'b00};
        if (exl_clr) sr_exl <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: vector table plus directed timer and reset sequences.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_in;
  logic [31:0] cp0_out;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code;
  logic        exl_clr;
  logic [5:0]  hwint;
  logic        req;
  logic [31:0] epc_out;

  int checks = 0;
  int errors = 0;

  cp0_unit #(
    .HWINT_N  (6),
    .TIMER_EN (1'b1),
    .PRID     (32'h0000_4010)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .cp0_addr (cp0_addr),
    .cp0_in   (cp0_in),
    .cp0_out  (cp0_out),
    .vpc      (vpc),
    .bd_in    (bd_in),
    .exc_code (exc_code),
    .exl_clr  (exl_clr),
    .hwint    (hwint),
    .req      (req),
    .epc_out  (epc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] vpc;
    logic        bd;
    logic [4:0]  exc;
    logic        eret;
    logic [5:0]  hw;
    logic        exp_req;
    logic [31:0] exp_out;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc,
                     input logic b, input logic [4:0] x, input logic r, input logic [5:0] h,
                     input logic q, input logic [31:0] o, input logic [31:0] ep);
    vec_t v;
    v.en = e; v.addr = a; v.din = d; v.vpc = pc; v.bd = b; v.exc = x; v.eret = r; v.hw = h;
    v.exp_req = q; v.exp_out = o; v.exp_epc = ep;
    vq.push_back(v);
  endtask

  // Apply inputs just after the falling edge and let them settle.
  task automatic drive(input logic e, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc,
                       input logic b, input logic [4:0] x, input logic r, input logic [5:0] h);
    @(negedge clk);
    en = e; cp0_addr = a; cp0_in = d; vpc = pc; bd_in = b; exc_code = x; exl_clr = r; hwint = h;
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 0; cp0_addr = 0; cp0_in = 0; vpc = 0; bd_in = 0;
    exc_code = 0; exl_clr = 0; hwint = 0;

    //  en addr   din           vpc        bd exc eret hw     req out           epc
    add(0, 5'd12, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0000, 32'h0);      // 0
    add(0, 5'd13, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0000, 32'h0);      // 1
    add(0, 5'd15, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_4010, 32'h0);      // 2
    add(0, 5'd14, 32'h0,        32'h3010,  1, 12, 0, 6'h00, 1, 32'h0000_0000, 32'h0);      // 3 Ov in delay slot
    add(0, 5'd14, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_300C, 32'h300C);   // 4
    add(0, 5'd13, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h8000_0030, 32'h300C);   // 5
    add(0, 5'd12, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0002, 32'h300C);   // 6
    add(0, 5'd12, 32'h0,        32'h0,     0, 4,  0, 6'h00, 0, 32'h0000_0002, 32'h300C);   // 7 EXL blocks
    add(0, 5'd12, 32'h0,        32'h0,     0, 0,  1, 6'h00, 0, 32'h0000_0002, 32'h300C);   // 8 eret
    add(1, 5'd12, 32'h0000_0401,32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0000, 32'h300C);   // 9
    add(0, 5'd12, 32'h0,        32'h0,     0, 0,  0, 6'h01, 0, 32'h0000_0401, 32'h300C);   // 10 hwint[0] pulse
    add(0, 5'd13, 32'h0,        32'h2000,  0, 4,  0, 6'h00, 1, 32'h8000_0430, 32'h300C);   // 11 int beats AdEL
    add(0, 5'd13, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0000, 32'h2000);   // 12
    add(0, 5'd14, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_2000, 32'h2000);   // 13
    add(0, 5'd12, 32'h0,        32'h0,     0, 0,  1, 6'h00, 0, 32'h0000_0403, 32'h2000);   // 14 eret
    add(1, 5'd12, 32'h0,        32'h4000,  0, 8,  0, 6'h00, 1, 32'h0000_0401, 32'h2000);   // 15 lost mtc0
    add(0, 5'd12, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0403, 32'h4000);   // 16
    add(0, 5'd13, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0020, 32'h4000);   // 17
    add(0, 5'd12, 32'h0,        32'h0,     0, 0,  1, 6'h00, 0, 32'h0000_0403, 32'h4000);   // 18 eret
    add(0, 5'd12, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0401, 32'h4000);   // 19
    add(1, 5'd14, 32'h0000_3003,32'h0,     0, 0,  1, 6'h00, 0, 32'h0000_4000, 32'h3000);   // 20 EPC bypass
    add(0, 5'd14, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_3000, 32'h3000);   // 21
    add(1, 5'd3,  32'h0000_0123,32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0000, 32'h3000);   // 22 unimplemented
    add(1, 5'd13, 32'hFFFF_FFFF,32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0020, 32'h3000);   // 23 Cause read-only
    add(0, 5'd13, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0020, 32'h3000);   // 24
    add(1, 5'd12, 32'hFFFF_FFFC,32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0401, 32'h3000);   // 25
    add(0, 5'd12, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_FC00, 32'h3000);   // 26
    add(0, 5'd12, 32'h0,        32'h0,     0, 0,  0, 6'h3F, 0, 32'h0000_FC00, 32'h3000);   // 27
    add(0, 5'd13, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_FC20, 32'h3000);   // 28 IE=0 masks
    add(0, 5'd13, 32'h0,        32'h0,     0, 0,  0, 6'h00, 0, 32'h0000_0020, 32'h3000);   // 29

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("reset_req", {31'b0, req}, 32'h0);
    check("reset_sr", cp0_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].en, vq[i].addr, vq[i].din, vq[i].vpc, vq[i].bd, vq[i].exc, vq[i].eret, vq[i].hw);
      check($sformatf("vec%0d_req", i), {31'b0, req}, {31'b0, vq[i].exp_req});
      check($sformatf("vec%0d_out", i), cp0_out, vq[i].exp_out);
      check($sformatf("vec%0d_epc", i), epc_out, vq[i].exp_epc);
    end

    // Timer: Compare=3, Count=0, TI after Count passes 3, interrupt via IM[15]
    drive(1, 5'd12, 32'h0000_8001, 0, 0, 0, 0, 0);
    drive(1, 5'd11, 32'd3, 0, 0, 0, 0, 0);
    drive(1, 5'd9,  32'd0, 0, 0, 0, 0, 0);
    for (int unsigned k = 0; k < 4; k++) begin
      drive(0, 5'd9, 0, 0, 0, 0, 0, 0);
      check($sformatf("tmr_count%0d", k), cp0_out, k);
      check($sformatf("tmr_noreq%0d", k), {31'b0, req}, 32'h0);
    end
    drive(0, 5'd13, 0, 32'h5000, 0, 0, 0, 0);
    check("tmr_ti_ip", cp0_out & 32'hC000_8000, 32'h4000_8000);
    check("tmr_req", {31'b0, req}, 32'h1);
    drive(0, 5'd13, 0, 0, 0, 0, 0, 0);
    check("tmr_cause", cp0_out, 32'h4000_8000);
    check("tmr_blocked", {31'b0, req}, 32'h0);
    drive(1, 5'd11, 32'd0, 0, 0, 0, 1, 0);
    check("tmr_clr_req", {31'b0, req}, 32'h0);
    drive(0, 5'd13, 0, 0, 0, 0, 0, 0);
    check("tmr_ti_clr", cp0_out, 32'h0);
    check("tmr_noreq_after", {31'b0, req}, 32'h0);
    drive(0, 5'd12, 0, 0, 0, 0, 0, 0);
    check("tmr_sr", cp0_out, 32'h0000_8001);

    // Reset mid-run with EXL=1 and Count=5
    drive(1, 5'd9, 32'd4, 0, 0, 0, 0, 0);
    drive(0, 5'd9, 0, 32'h6000, 0, 10, 0, 0);
    check("mid_count4", cp0_out, 32'd4);
    check("mid_req", {31'b0, req}, 32'h1);
    drive(0, 5'd9, 0, 0, 0, 0, 0, 0);
    check("mid_count5", cp0_out, 32'd5);
    exc_code = 5'd10;
    reset = 1'b1;
    #1;
    check("mid_rst_count", cp0_out, 32'h0);
    check("mid_rst_req", {31'b0, req}, 32'h0);
    cp0_addr = 5'd12; #1;
    check("mid_rst_sr", cp0_out, 32'h0);
    cp0_addr = 5'd14; #1;
    check("mid_rst_epc", cp0_out, 32'h0);
    check("mid_rst_epc_out", epc_out, 32'h0);
    drive(0, 5'd13, 0, 0, 0, 0, 0, 0);
    check("mid_rst_cause", cp0_out, 32'h0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
